prm_edge_chk_sched: RTL and testbench

// Scheduler for the bank of PRM obstacle-logic edge checkers (prm_oblgc_chk*). Each checker maps
// the 15-bit occupancy vector A..O to one edge_mask bit (1 = edge blocked).

---
 rtl/prm_edge_chk_sched.sv | 158 +++++++++++++++
 tb/tb_prm_edge_chk_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_chk_sched.sv
// Sweeps the PRM edge-checker bank one group of NCHK edges per cycle against a snapshot
// occupancy vector and streams blocked-edge bitmaps. Optional blocked-edge count: PRM_BLOCK_CNT_EN.
module prm_edge_chk_sched #(
  parameter int NUM_EDGES = 1000,
  parameter int NCHK      = 32,
  localparam int NUM_GRP  = (NUM_EDGES + NCHK - 1) / NCHK,
  localparam int GRP_W    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
  localparam int CNT_W    = $clog2(NUM_EDGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [14:0]      occ_vec_i,
  output logic [14:0]      chk_occ_o,
  output logic [GRP_W-1:0] chk_grp_o,
  input  logic [NCHK-1:0]  chk_mask_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [NCHK-1:0]  res_data_o,
  output logic [GRP_W-1:0] res_grp_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam int LAST_LANES = NUM_EDGES - (NUM_GRP - 1) * NCHK;
  localparam logic [NCHK-1:0] LAST_MASK = {NCHK{1'b1}} >> (NCHK - LAST_LANES);

  state_t             state_q, state_d;
  logic [14:0]        occ_q, occ_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic               res_valid_q, res_valid_d;
  logic [NCHK-1:0]    res_data_q, res_data_d;
  logic [GRP_W-1:0]   res_grp_q, res_grp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture;
  logic               last_grp;
  logic [NCHK-1:0]    lane_mask;

  // Result channel: a word transfers on a cycle where res_valid_o & res_ready_i; once valid is
  // raised, res_data_o/res_grp_o hold unchanged until that transfer completes.
  assign capture   = !res_valid_q || res_ready_i;
  assign last_grp  = (grp_q == GRP_W'(NUM_GRP - 1));
  assign lane_mask = last_grp ? LAST_MASK : {NCHK{1'b1}};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SCAN;
      S_SCAN:  if (capture && last_grp) state_d = S_DRAIN;
      S_DRAIN: if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_comb begin
    occ_d       = occ_q;
    grp_d       = grp_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_grp_d   = res_grp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (abort_i) begin
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          occ_d  = occ_vec_i;
          grp_d  = '0;
          busy_d = 1'b1;
        end
        S_SCAN: if (capture) begin
          res_data_d  = chk_mask_i & lane_mask;
          res_grp_d   = grp_q;
          res_valid_d = 1'b1;
          if (!last_grp) grp_d = grp_q + GRP_W'(1);
        end
        S_DRAIN: if (res_ready_i) begin
          res_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q       <= '0;
      grp_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_grp_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      grp_q       <= grp_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_grp_q   <= res_grp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef PRM_BLOCK_CNT_EN
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [NCHK-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCHK; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (!abort_i && state_q == S_IDLE && start_i)
      blk_cnt_d = '0;
    else if (!abort_i && state_q == S_SCAN && capture)
      blk_cnt_d = blk_cnt_q + popcount(res_data_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) blk_cnt_q <= '0;
    else       blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt_o = blk_cnt_q;
`else
  assign blk_cnt_o = '0;
`endif

  assign chk_occ_o   = occ_q;
  assign chk_grp_o   = grp_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_grp_o   = res_grp_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Bench for prm_edge_chk_sched: table of runs checked by a scoreboard fed from an edge-level
// model, plus hand-written backpressure, abort, reset, control and 64-edge sequences.
module tb_prm_edge_chk_sched;
  localparam int NE  = 1000;
  localparam int NC  = 32;
  localparam int NG  = (NE + NC - 1) / NC;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW  = $clog2(NE + 1);
  localparam int EW  = GW + NC;
  localparam int SNE = 64;
  localparam int SCW = $clog2(SNE + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start, abort, res_ready;
  logic [14:0]   occ_vec, chk_occ;
  logic [GW-1:0] chk_grp, res_grp;
  logic [NC-1:0] chk_mask, res_data;
  logic          res_valid, busy, done;
  logic [CW-1:0] blk_cnt;
  logic [1:0]    dbg_state;

  prm_edge_chk_sched #(.NUM_EDGES(NE), .NCHK(NC)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .occ_vec_i(occ_vec),
    .chk_occ_o(chk_occ), .chk_grp_o(chk_grp), .chk_mask_i(chk_mask),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_grp_o(res_grp), .busy_o(busy), .done_o(done), .blk_cnt_o(blk_cnt),
    .dbg_state_o(dbg_state)
  );

  logic           s_start, s_valid, s_busy, s_done;
  logic [14:0]    s_chk_occ;
  logic [0:0]     s_chk_grp, s_grp;
  logic [NC-1:0]  s_data;
  logic [NC-1:0]  s_mask;
  logic [SCW-1:0] s_blk;
  logic [1:0]     s_state;
  assign s_mask = '1;

  prm_edge_chk_sched #(.NUM_EDGES(SNE), .NCHK(NC)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .abort_i(1'b0), .occ_vec_i(15'h0),
    .chk_occ_o(s_chk_occ), .chk_grp_o(s_chk_grp), .chk_mask_i(s_mask),
    .res_valid_o(s_valid), .res_ready_i(1'b1), .res_data_o(s_data),
    .res_grp_o(s_grp), .busy_o(s_busy), .done_o(s_done), .blk_cnt_o(s_blk),
    .dbg_state_o(s_state)
  );

  typedef struct {
    logic [14:0] occ;
    int          mode;
    bit          rnd;
    int          exp_first;
    int          exp_done;
  } vec_t;

  int          mode_r = 0;
  logic [14:0] run_occ = '0;
  logic [EW-1:0] exp_q[$];
  int exp_blk;
  int c0 = 0;
  int n_chk = 0, n_fail = 0;
  bit done_seen, first_seen;
  int done_cyc, first_cyc;
  int done_cnt = 0;

  // Edge-level obstacle model: mode 0 all blocked, 1 none blocked, 2 occupancy-dependent.
  function automatic bit blocked(input logic [14:0] occ, input int e, input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return occ[e % 15] ^ e[4];
    endcase
  endfunction

  always_comb begin
    chk_mask = '0;
    for (int l = 0; l < NC; l++) chk_mask[l] = blocked(chk_occ, int'(chk_grp) * NC + l, mode_r);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) check("chk_occ_snapshot", 64'(chk_occ), 64'(run_occ));
      if (res_valid && res_ready) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc - c0;
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got grp %0d data %0h expected nothing", res_grp, res_data);
        end else begin
          check("result_word", 64'({res_grp, res_data}), 64'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        if (!done_seen) begin
          done_seen = 1'b1;
          done_cyc  = cyc - c0;
        end
      end
    end
  end

  // driver tasks
  task automatic start_run(input logic [14:0] occ, input int mode);
    logic [NC-1:0] d;
    int e;
    mode_r = mode;
    run_occ = occ;
    exp_q.delete();
    exp_blk = 0;
    for (int g = 0; g < NG; g++) begin
      d = '0;
      for (int l = 0; l < NC; l++) begin
        e = g * NC + l;
        if (e < NE && blocked(occ, e, mode)) begin
          d[l] = 1'b1;
          exp_blk++;
        end
      end
      exp_q.push_back({GW'(g), d});
    end
`ifndef PRM_BLOCK_CNT_EN
    exp_blk = 0;
`endif
    done_seen  = 1'b0;
    first_seen = 1'b0;
    start      = 1'b1;
    occ_vec    = occ;
    res_ready  = 1'b1;
    c0         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input bit rnd);
    res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    occ_vec   = 15'($urandom);
    start     = rnd && (cyc - c0 <= NG) && ($urandom_range(0, 5) == 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int exp_first, input int exp_done);
    int k = 0;
    while (!done_seen && k < 3000) begin
      step(rnd);
      k++;
    end
    if (!done_seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", k);
    end else begin
      check("leftover_groups", 64'(exp_q.size()), 64'd0);
      check("blk_cnt_final", 64'(blk_cnt), 64'(exp_blk));
      check("busy_after_done", 64'(busy), 64'd0);
      if (exp_done != 0) begin
        check("first_valid_cycle", 64'(first_cyc), 64'(exp_first));
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_chk_occ"}, 64'(chk_occ), 64'd0);
    check({tag, "_chk_grp"}, 64'(chk_grp), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_res_grp"}, 64'(res_grp), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int dc;
    tbl[0] = '{15'h01A5, 0, 1'b0, 2, 34};
    tbl[1] = '{15'h0000, 1, 1'b0, 2, 34};
    tbl[2] = '{15'h7FFF, 2, 1'b0, 2, 34};
    tbl[3] = '{15'h2B3C, 2, 1'b1, 0, 0};
    tbl[4] = '{15'h5555, 2, 1'b1, 0, 0};
    tbl[5] = '{15'h1234, 0, 1'b1, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1; occ_vec = '0; s_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      start_run(tbl[i].occ, tbl[i].mode);
      wait_done(tbl[i].rnd, tbl[i].exp_first, tbl[i].exp_done);
    end

    // backpressure while group 4 is presented
    start_run(15'h0F0F, 2);
    while (cyc - c0 < 6) step(1'b0);
    for (int k = 0; k < 5; k++) begin
      res_ready = 1'b0;
      occ_vec   = 15'($urandom);
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_res_grp", 64'(res_grp), 64'd4);
      check("bp_chk_grp", 64'(chk_grp), 64'd5);
      check("bp_res_data", 64'(res_data), 64'(exp_q[0][NC-1:0]));
      @(posedge clk); #1;
    end
    wait_done(1'b0, 2, 39);

    // start while busy
    start_run(15'h0333, 2);
    while (cyc - c0 < 5) step(1'b0);
    start = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy_chk_grp", 64'(chk_grp), 64'd5);
    wait_done(1'b0, 2, 34);

    // abort at group 10, then restart
    start_run(15'h3C3C, 2);
    while (cyc - c0 < 12) step(1'b0);
    check("abort_at_grp", 64'(res_grp), 64'd10);
    abort = 1'b1;
    dc = done_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(res_valid), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    repeat (40) step(1'b0);
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    start_run(15'h6A6A, 0);
    check("restart_chk_grp", 64'(chk_grp), 64'd0);
    check("restart_blk_cnt", 64'(blk_cnt), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    wait_done(1'b0, 2, 34);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_state", 64'(dbg_state), 64'd0);
    check("start_abort_busy", 64'(busy), 64'd0);

    // reset mid-run
    start_run(15'h1111, 2);
    repeat (10) step(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst1");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check_zero("midrst2");

    // 64-edge instance: two fully valid groups
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("small_busy", 64'(s_busy), 64'd1);
    @(posedge clk); #1;
    check("small_g0_valid", 64'(s_valid), 64'd1);
    check("small_g0_grp", 64'(s_grp), 64'd0);
    check("small_g0_data", 64'(s_data), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    check("small_g1_valid", 64'(s_valid), 64'd1);
    check("small_g1_grp", 64'(s_grp), 64'd1);
    check("small_g1_data", 64'(s_data), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    check("small_done", 64'(s_done), 64'd1);
    check("small_valid_off", 64'(s_valid), 64'd0);
`ifdef PRM_BLOCK_CNT_EN
    check("small_blk_cnt", 64'(s_blk), 64'd64);
`else
    check("small_blk_cnt", 64'(s_blk), 64'd0);
`endif
    @(posedge clk); #1;
    check("small_done_pulse", 64'(s_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
